// File: rtl/sha3_absorb.sv
// rtl/sha3_absorb.sv - SHA3 absorb front end: lane XOR, pad10*1, permutation handshake
// Optional SHAKE domain byte (0x1F) and XOF_MODE port under SHA3_ABSORB_XOF_EN.
module sha3_absorb #(
   parameter int RATE_LANES = 17
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic [63:0]   IN_DATA,
   input  logic [3:0]    IN_BYTES,
   input  logic          IN_LAST,
   input  logic          IN_VALID,
   output logic          IN_READY,
`ifdef SHA3_ABSORB_XOF_EN
   input  logic          XOF_MODE,
`endif
   output logic [0:1599] PERM_STATE_OUT,
   output logic          PERM_START,
   input  logic          PERM_DONE,
   input  logic [0:1599] PERM_STATE_IN,
   output logic [0:1599] STATE_OUT,
   output logic          DIGEST_VALID,
   input  logic          DIGEST_READY
);
   typedef enum logic [1:0] {ABSORB, PAD, PERM, DONE} fsm_t;
   localparam int RATE_BYTES = RATE_LANES * 8;

   fsm_t          fsm_q, fsm_d;
   logic [0:1599] state_q, state_d;
   logic [4:0]    lane_cnt_q, lane_cnt_d;
   logic [7:0]    pad_pos_q, pad_pos_d;
   logic [7:0]    dom_q, dom_d;
   logic          final_q, final_d;
   logic          pad_pend_q, pad_pend_d;
   logic          first_q, first_d;

   logic [3:0]    nbytes;
   logic [63:0]   lane_m;
   logic [7:0]    p_calc;
   logic [7:0]    dom_sel;
   int            base;

   // Lane L sits at x = L%5, y = L/5 in the 5x5 lane grid
   function automatic int lane_base(input int l);
      return (l / 5) * 320 + (l % 5) * 64;
   endfunction

   assign nbytes = (IN_LAST && IN_BYTES < 4'd8) ? IN_BYTES : 4'd8;
   assign p_calc = {lane_cnt_q, 3'b000} + {4'b0000, nbytes};

`ifdef SHA3_ABSORB_XOF_EN
   assign dom_sel = XOF_MODE ? 8'h1F : 8'h06;
`else
   assign dom_sel = 8'h06;
`endif

   always_comb begin
      lane_m = '0;
      for (int k = 0; k < 8; k++) begin
         if (4'(k) < nbytes) lane_m[8*k +: 8] = IN_DATA[8*k +: 8];
      end
   end

   always_comb begin
      fsm_d      = fsm_q;
      state_d    = state_q;
      lane_cnt_d = lane_cnt_q;
      pad_pos_d  = pad_pos_q;
      dom_d      = dom_q;
      final_d    = final_q;
      pad_pend_d = pad_pend_q;
      first_d    = 1'b0;
      base       = 0;
      case (fsm_q)
         ABSORB: begin
            if (IN_VALID) begin
               base = lane_base(int'(lane_cnt_q));
               for (int z = 0; z < 64; z++) begin
                  state_d[11'(base + z)] = state_q[11'(base + z)] ^ lane_m[z];
               end
               lane_cnt_d = lane_cnt_q + 5'd1;
               if (IN_LAST) begin
                  dom_d      = dom_sel;
                  lane_cnt_d = '0;
                  if (int'(p_calc) == RATE_BYTES) begin
                     // Block exactly full: permute the data first, pad into a fresh block
                     fsm_d      = PERM;
                     first_d    = 1'b1;
                     pad_pend_d = 1'b1;
                     pad_pos_d  = '0;
                  end else begin
                     fsm_d     = PAD;
                     pad_pos_d = p_calc;
                  end
               end else if (int'(lane_cnt_q) == RATE_LANES - 1) begin
                  fsm_d      = PERM;
                  first_d    = 1'b1;
                  final_d    = 1'b0;
                  lane_cnt_d = '0;
               end
            end
         end
         PAD: begin
            base = lane_base(int'(pad_pos_q[7:3])) + 8 * int'(pad_pos_q[2:0]);
            for (int j = 0; j < 8; j++) begin
               state_d[11'(base + j)] = state_d[11'(base + j)] ^ dom_q[j];
            end
            // Sequential XOR makes a coinciding last byte come out as dom|0x80
            state_d[11'(lane_base(RATE_LANES - 1) + 63)] =
               state_d[11'(lane_base(RATE_LANES - 1) + 63)] ^ 1'b1;
            fsm_d   = PERM;
            first_d = 1'b1;
            final_d = 1'b1;
         end
         PERM: begin
            if (PERM_DONE) begin
               state_d = PERM_STATE_IN;
               if (pad_pend_q) begin
                  fsm_d      = PAD;
                  pad_pend_d = 1'b0;
               end else if (final_q) begin
                  fsm_d = DONE;
               end else begin
                  fsm_d = ABSORB;
               end
            end
         end
         DONE: begin
            if (DIGEST_READY) begin
               state_d    = '0;
               lane_cnt_d = '0;
               final_d    = 1'b0;
               pad_pend_d = 1'b0;
               fsm_d      = ABSORB;
            end
         end
         default: fsm_d = ABSORB;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         fsm_q      <= ABSORB;
         state_q    <= '0;
         lane_cnt_q <= '0;
         pad_pos_q  <= '0;
         dom_q      <= 8'h06;
         final_q    <= 1'b0;
         pad_pend_q <= 1'b0;
         first_q    <= 1'b0;
      end else begin
         fsm_q      <= fsm_d;
         state_q    <= state_d;
         lane_cnt_q <= lane_cnt_d;
         pad_pos_q  <= pad_pos_d;
         dom_q      <= dom_d;
         final_q    <= final_d;
         pad_pend_q <= pad_pend_d;
         first_q    <= first_d;
      end
   end

   assign IN_READY       = (fsm_q == ABSORB);
   assign PERM_START     = (fsm_q == PERM) && first_q;
   assign DIGEST_VALID   = (fsm_q == DONE);
   assign PERM_STATE_OUT = state_q;
   assign STATE_OUT      = state_q;
endmodule

// File: tb/tb_sha3_absorb.sv
// tb/tb_sha3_absorb.sv - randomized bench for sha3_absorb against a byte-level sponge model
module tb_sha3_absorb;
   localparam int R  = 17;
   localparam int RB = R * 8;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic [63:0]   IN_DATA = '0;
   logic [3:0]    IN_BYTES = '0;
   logic          IN_LAST = 1'b0;
   logic          IN_VALID = 1'b0;
   logic          IN_READY;
   logic [0:1599] PERM_STATE_OUT;
   logic          PERM_START;
   logic          PERM_DONE = 1'b0;
   logic [0:1599] PERM_STATE_IN = '0;
   logic [0:1599] STATE_OUT;
   logic          DIGEST_VALID;
   logic          DIGEST_READY = 1'b0;

   int            n_cmp = 0;
   int            n_bad = 0;
   int            n_perm = 0;
   logic [0:1599] mdl = '0;
   byte unsigned  msg[$];

   always #5 CLK = ~CLK;

   sha3_absorb #(.RATE_LANES(R)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .IN_DATA(IN_DATA), .IN_BYTES(IN_BYTES), .IN_LAST(IN_LAST),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY),
`ifdef SHA3_ABSORB_XOF_EN
      .XOF_MODE(1'b0),
`endif
      .PERM_STATE_OUT(PERM_STATE_OUT), .PERM_START(PERM_START),
      .PERM_DONE(PERM_DONE), .PERM_STATE_IN(PERM_STATE_IN),
      .STATE_OUT(STATE_OUT), .DIGEST_VALID(DIGEST_VALID), .DIGEST_READY(DIGEST_READY)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // The state vector is 25 consecutive 64-bit lanes, lane L = x + 5y
   function automatic logic [63:0] lane_of(input logic [0:1599] s, input int l);
      logic [63:0] v;
      for (int z = 0; z < 64; z++) v[z] = s[11'(64 * l + z)];
      return v;
   endfunction

   task automatic chk_state(input string tag, input logic [0:1599] obs);
      for (int l = 0; l < 25; l++)
         chk($sformatf("%s lane%0d", tag, l), lane_of(obs, l), lane_of(mdl, l));
   endtask

   task automatic absorb(input byte unsigned pm[$], input int blk);
      for (int m = 0; m < RB; m++)
         for (int j = 0; j < 8; j++)
            mdl[11'(8 * m + j)] = mdl[11'(8 * m + j)] ^ pm[blk * RB + m][j];
   endtask

   // Entered on the cycle PERM_START is expected; leaves one cycle after PERM_DONE
   task automatic do_perm(input string tag);
      logic [0:1599] nxt;
      int d;
      chk_state({tag, " perm_out"}, PERM_STATE_OUT);
      if (n_perm == 0) nxt = '1;
      else for (int i = 0; i < 50; i++) nxt[32 * i +: 32] = $urandom;
      d = $urandom_range(0, 3);
      IN_VALID = 1'b1;
      IN_LAST  = 1'b0;
      IN_DATA  = {$urandom, $urandom};
      for (int c = 0; c < d; c++) begin
         @(posedge CLK); @(negedge CLK);
         chk({tag, " busy_ready"}, 64'(IN_READY), 64'd0);
         chk({tag, " start_once"}, 64'(PERM_START), 64'd0);
      end
      PERM_DONE     = 1'b1;
      PERM_STATE_IN = nxt;
      @(posedge CLK); @(negedge CLK);
      PERM_DONE     = 1'b0;
      IN_VALID      = 1'b0;
      PERM_STATE_IN = '0;
      mdl = nxt;
      n_perm++;
   endtask

   task automatic run_msg(input byte unsigned m[$], input string tag);
      byte unsigned pm[$];
      int n, nl, q, blk, nb, li, p;
      n  = m.size();
      pm = m;
      q  = RB - (n % RB);
      if (q == 1) pm.push_back(8'h86);
      else begin
         pm.push_back(8'h06);
         repeat (q - 2) pm.push_back(8'h00);
         pm.push_back(8'h80);
      end
      nl  = (n == 0) ? 1 : (n + 7) / 8;
      blk = 0;
      for (int i = 0; i < nl; i++) begin
         nb = (i == nl - 1) ? n - 8 * i : 8;
         IN_DATA = {$urandom, $urandom};
         for (int k = 0; k < nb; k++) IN_DATA[8 * k +: 8] = m[8 * i + k];
         IN_LAST = (i == nl - 1);
         if (i != nl - 1) IN_BYTES = 4'($urandom_range(0, 15));
         else if (nb == 8) IN_BYTES = 4'($urandom_range(8, 15));
         else IN_BYTES = 4'(nb);
         IN_VALID = 1'b1;
         chk({tag, " in_ready"}, 64'(IN_READY), 64'd1);
         @(posedge CLK); @(negedge CLK);
         IN_VALID = 1'b0;
         li = i % R;
         if (i != nl - 1) begin
            if (li == R - 1) begin
               chk({tag, " blk_start"}, 64'(PERM_START), 64'd1);
               absorb(pm, blk); blk++;
               do_perm(tag);
            end
         end else begin
            p = li * 8 + nb;
            if (p == RB) begin
               chk({tag, " full_start"}, 64'(PERM_START), 64'd1);
               absorb(pm, blk); blk++;
               do_perm(tag);
            end
            chk({tag, " pad_start"}, 64'(PERM_START), 64'd0);
            chk({tag, " pad_ready"}, 64'(IN_READY), 64'd0);
            @(posedge CLK); @(negedge CLK);
            chk({tag, " fin_start"}, 64'(PERM_START), 64'd1);
            absorb(pm, blk); blk++;
            do_perm(tag);
         end
      end
      chk({tag, " dig_valid"}, 64'(DIGEST_VALID), 64'd1);
      chk_state({tag, " digest"}, STATE_OUT);
      IN_VALID = 1'b1; IN_LAST = 1'b1; IN_BYTES = 4'd3; IN_DATA = {$urandom, $urandom};
      @(posedge CLK); @(negedge CLK);
      chk({tag, " done_ready"}, 64'(IN_READY), 64'd0);
      chk({tag, " dig_hold"}, 64'(DIGEST_VALID), 64'd1);
      chk_state({tag, " digest_hold"}, STATE_OUT);
      IN_VALID = 1'b0; IN_LAST = 1'b0;
      DIGEST_READY = 1'b1;
      @(posedge CLK); @(negedge CLK);
      DIGEST_READY = 1'b0;
      mdl = '0;
      chk({tag, " dig_drop"}, 64'(DIGEST_VALID), 64'd0);
      chk({tag, " idle_ready"}, 64'(IN_READY), 64'd1);
      chk_state({tag, " cleared"}, STATE_OUT);
   endtask

   task automatic rand_msg(input int n);
      msg.delete();
      repeat (n) msg.push_back(8'($urandom));
   endtask

   initial begin
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst ready", 64'(IN_READY), 64'd1);
      chk("rst start", 64'(PERM_START), 64'd0);
      chk("rst valid", 64'(DIGEST_VALID), 64'd0);
      chk_state("rst state", STATE_OUT);
      RST_N = 1'b1;
      @(negedge CLK);

      msg.delete();
      run_msg(msg, "empty");
      msg = {8'h61, 8'h62, 8'h63};
      run_msg(msg, "abc");
      rand_msg(136); run_msg(msg, "len136");
      rand_msg(135); run_msg(msg, "len135");
      rand_msg(8);   run_msg(msg, "len8");
      rand_msg(272); run_msg(msg, "len272");
      for (int t = 0; t < 6; t++) begin
         rand_msg($urandom_range(1, 300));
         run_msg(msg, $sformatf("rnd%0d", t));
      end

      // Empty message driven by hand, then reset while the permutation is pending
      IN_VALID = 1'b1; IN_LAST = 1'b1; IN_BYTES = 4'd0; IN_DATA = {$urandom, $urandom};
      @(posedge CLK); @(negedge CLK);
      IN_VALID = 1'b0; IN_LAST = 1'b0;
      @(posedge CLK); @(negedge CLK);
      chk("mid start", 64'(PERM_START), 64'd1);
      chk("mid lane0", lane_of(PERM_STATE_OUT, 0), 64'h0000000000000006);
      chk("mid lane16", lane_of(PERM_STATE_OUT, 16), 64'h8000000000000000);
      #2 RST_N = 1'b0;
      #1;
      mdl = '0;
      chk("arst ready", 64'(IN_READY), 64'd1);
      chk("arst start", 64'(PERM_START), 64'd0);
      chk_state("arst state", PERM_STATE_OUT);
      @(posedge CLK); @(negedge CLK);
      RST_N = 1'b1;
      PERM_DONE = 1'b1; PERM_STATE_IN = '1;
      @(posedge CLK); @(negedge CLK);
      PERM_DONE = 1'b0; PERM_STATE_IN = '0;
      chk("late ready", 64'(IN_READY), 64'd1);
      chk("late valid", 64'(DIGEST_VALID), 64'd0);
      chk_state("late state", STATE_OUT);

      rand_msg($urandom_range(140, 200));
      run_msg(msg, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
